// File: rtl/char_text_buffer_pkg.sv
// Shared types and message constants for the character text buffer.
// Messages are stored index 0 = first character; unused slots hold spaces.
package char_text_buffer_pkg;

  typedef enum logic [1:0] {CLEAR, WRITE, IDLE, SHOWN} text_state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_P1, SEL_P2, SEL_DRAW} sel_t;

  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef struct packed {
    logic [15:0][6:0] text;
    logic [4:0]       len;
  } msg_t;

  localparam msg_t MSG_NONE = '{text: {16{CHAR_SPACE}}, len: 5'd0};

  // "PLAYER 1 WINS"
  localparam msg_t MSG_P1 = '{
    text: {{3{CHAR_SPACE}}, 7'h53, 7'h4E, 7'h49, 7'h57, CHAR_SPACE, 7'h31,
           CHAR_SPACE, 7'h52, 7'h45, 7'h59, 7'h41, 7'h4C, 7'h50},
    len: 5'd13};

  // "PLAYER 2 WINS"
  localparam msg_t MSG_P2 = '{
    text: {{3{CHAR_SPACE}}, 7'h53, 7'h4E, 7'h49, 7'h57, CHAR_SPACE, 7'h32,
           CHAR_SPACE, 7'h52, 7'h45, 7'h59, 7'h41, 7'h4C, 7'h50},
    len: 5'd13};

  // "DRAW"
  localparam msg_t MSG_DRAW = '{
    text: {{12{CHAR_SPACE}}, 7'h57, 7'h41, 7'h52, 7'h44},
    len: 5'd4};

  function automatic sel_t sel_decode(input logic p1, input logic p2);
    case ({p1, p2})
      2'b10:   return SEL_P1;
      2'b01:   return SEL_P2;
      2'b11:   return SEL_DRAW;
      default: return SEL_NONE;
    endcase
  endfunction

  function automatic msg_t msg_lookup(input sel_t sel);
    case (sel)
      SEL_P1:   return MSG_P1;
      SEL_P2:   return MSG_P2;
      SEL_DRAW: return MSG_DRAW;
      default:  return MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/char_text_buffer_font_rom.sv
// 2048 x 8 synchronous glyph ROM addressed by {code, line}; read stage 2.
// Glyphs are 8x8 drawn on lines 4..11; control codes, space and DEL are blank.
module font_rom (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  function automatic logic [63:0] glyph(input logic [6:0] c);
    logic [63:0] g;
    g = 64'hFF8181818181FF00;
    case (c)
      7'h31: g = 64'h1838181818187E00;
      7'h32: g = 64'h3C66060C30607E00;
      7'h41: g = 64'h183C66667E666600;
      7'h44: g = 64'h786C6666666C7800;
      7'h45: g = 64'h7E60607C60607E00;
      7'h49: g = 64'h3C18181818183C00;
      7'h4C: g = 64'h6060606060607E00;
      7'h4E: g = 64'h66767E7E6E666600;
      7'h50: g = 64'h7C66667C60606000;
      7'h52: g = 64'h7C66667C786C6600;
      7'h53: g = 64'h3C66603C06663C00;
      7'h57: g = 64'h6363636B7F776300;
      7'h59: g = 64'h6666663C18181800;
      default: if (c <= 7'h20 || c == 7'h7F) g = 64'h0;
    endcase
    return g;
  endfunction

  logic [6:0]  code;
  logic [3:0]  line;
  logic [63:0] bits;
  logic [2:0]  row;
  logic [5:0]  lsb;
  logic [7:0]  row_data;

  assign code     = addr[10:4];
  assign line     = addr[3:0];
  assign bits     = glyph(code);
  assign row      = 3'(line - 4'd4);
  assign lsb      = {3'd7 - row, 3'b000};
  assign row_data = (line >= 4'd4 && line <= 4'd11) ? bits[lsb +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) data <= 8'h00;
    else        data <= row_data;
  end

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 character grid with 2-cycle glyph read path and an end-of-game
// message sequencer.  state | meaning: CLEAR fill grid with spaces,
// WRITE place message, IDLE no message, SHOWN message on screen.
module char_text_buffer
  import char_text_buffer_pkg::*;
#(
  parameter int MSG_ROW = 7,
  parameter int MSG_COL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       endgame,
  input  logic       endgame2,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixel,
  output logic       busy,
  output logic       msg_shown
);

  text_state_t state, state_next;
  sel_t        sel, sel_latched;
  msg_t        msg;
  logic [7:0]  cnt, cnt_next;
  logic        last_write;
  logic        we, busy_next, shown_next;
  logic [7:0]  waddr;
  logic [6:0]  wdata;
  logic [6:0]  grid [256];
  logic [6:0]  code;
  logic [3:0]  line;

  assign sel        = sel_decode(endgame, endgame2);
  assign msg        = msg_lookup(sel_latched);
  assign last_write = (cnt == ({3'b000, msg.len} - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLEAR;
      cnt         <= '0;
      sel_latched <= SEL_NONE;
      busy        <= 1'b0;
      msg_shown   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      msg_shown <= shown_next;
      if (state == CLEAR && cnt == 8'hFF) sel_latched <= sel;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        cnt_next = cnt + 8'd1;
        if (cnt == 8'hFF) state_next = (sel != SEL_NONE) ? WRITE : IDLE;
      end
      WRITE: begin
        if (last_write) begin
          state_next = SHOWN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      IDLE:    if (sel != SEL_NONE) state_next = CLEAR;
      SHOWN:   if (sel != sel_latched) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Column wraps in 4 bits so long messages fold back to the row start.
  always_comb begin
    we         = 1'b0;
    waddr      = cnt;
    wdata      = CHAR_SPACE;
    busy_next  = (state == CLEAR) || (state == WRITE);
    shown_next = (state == SHOWN);
    case (state)
      CLEAR: we = 1'b1;
      WRITE: begin
        we    = 1'b1;
        waddr = {4'(MSG_COL) + cnt[3:0], 4'(MSG_ROW)};
        wdata = msg.text[cnt[3:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) grid[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code <= '0;
      line <= '0;
    end else begin
      code <= grid[char_xy];
      line <= char_line;
    end
  end

  font_rom u_font_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({code, line}),
    .data  (char_pixel)
  );

endmodule

// File: tb/tb_char_text_buffer.sv
// Bench for char_text_buffer: timeline model of the sequencer and grid,
// every-cycle compare, plus directed literal checks.
module tb_char_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       endgame = 1'b0;
  logic       endgame2 = 1'b0;
  logic [7:0] char_xy = 8'h00;
  logic [3:0] char_line = 4'h0;
  logic [7:0] px0, px1;
  logic       busy0, busy1, shown0, shown1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  char_text_buffer #(.MSG_ROW(7), .MSG_COL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .endgame(endgame), .endgame2(endgame2),
    .char_xy(char_xy), .char_line(char_line), .char_pixel(px0),
    .busy(busy0), .msg_shown(shown0));

  char_text_buffer #(.MSG_ROW(7), .MSG_COL(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .endgame(endgame), .endgame2(endgame2),
    .char_xy(char_xy), .char_line(char_line), .char_pixel(px1),
    .busy(busy1), .msg_shown(shown1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_glyph(input logic [6:0] c, input int ln);
    logic [63:0] g;
    if (ln < 4 || ln > 11) return 8'h00;
    case (c)
      7'h31: g = 64'h1838181818187E00;
      7'h32: g = 64'h3C66060C30607E00;
      7'h41: g = 64'h183C66667E666600;
      7'h44: g = 64'h786C6666666C7800;
      7'h45: g = 64'h7E60607C60607E00;
      7'h49: g = 64'h3C18181818183C00;
      7'h4C: g = 64'h6060606060607E00;
      7'h4E: g = 64'h66767E7E6E666600;
      7'h50: g = 64'h7C66667C60606000;
      7'h52: g = 64'h7C66667C786C6600;
      7'h53: g = 64'h3C66603C06663C00;
      7'h57: g = 64'h6363636B7F776300;
      7'h59: g = 64'h6666663C18181800;
      default: g = (c <= 7'h20 || c == 7'h7F) ? 64'h0 : 64'hFF8181818181FF00;
    endcase
    return g[8*(11-ln) +: 8];
  endfunction

  // Model: a pass is 256 space writes then one write per message char.
  string      msgs [4] = '{"", "PLAYER 1 WINS", "PLAYER 2 WINS", "DRAW"};
  logic [6:0] g_code [2][256];
  bit         g_ok   [2][256];
  logic [6:0] s1_code [2];
  bit         s1_ok   [2];
  int         s1_line = 0;
  logic [7:0] e_px [2];
  bit         e_ok [2];
  bit         e_busy = 1'b0, e_shown = 1'b0;
  int         mode = 0;          // 0 pass, 1 idle, 2 shown
  int         pass_start = 1, latched = 0, cyc = 0;

  always begin
    int sel_now, off, k, addr;
    bit wrote;
    @(posedge clk);
    cyc++;
    sel_now = (endgame && endgame2) ? 3 : endgame ? 1 : endgame2 ? 2 : 0;
    if (!rst_n) begin
      mode = 0; pass_start = cyc + 1; latched = 0;
      for (int i = 0; i < 2; i++) begin
        s1_code[i] = '0; s1_ok[i] = 1'b1; e_px[i] = '0; e_ok[i] = 1'b1;
      end
      s1_line = 0; e_busy = 1'b0; e_shown = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_px[i]    = s1_ok[i] ? tb_glyph(s1_code[i], s1_line) : 8'h00;
        e_ok[i]    = s1_ok[i];
        s1_code[i] = g_code[i][char_xy];
        s1_ok[i]   = g_ok[i][char_xy];
      end
      s1_line = int'(char_line);
      e_shown = (mode == 2);
      wrote   = 1'b0;
      if (mode == 0) begin
        off   = cyc - pass_start;
        wrote = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (off < 256) begin
            g_code[i][off] = 7'h20; g_ok[i][off] = 1'b1;
          end else begin
            k    = off - 256;
            addr = (((i == 1 ? 10 : 2) + k) % 16) * 16 + 7;
            g_code[i][addr] = 7'(msgs[latched][k]);
            g_ok[i][addr]   = 1'b1;
          end
        end
        if (off == 255) latched = sel_now;
        if (off == 255 + msgs[latched].len()) mode = (latched == 0) ? 1 : 2;
      end else if ((mode == 1 && sel_now != 0) || (mode == 2 && sel_now != latched)) begin
        mode = 0; pass_start = cyc + 1;
      end
      e_busy = wrote;
    end
  end

  always begin
    @(negedge clk);
    if (chk_en) begin
      if (e_ok[0]) chk("px0", int'(px0), int'(e_px[0]));
      if (e_ok[1]) chk("px1", int'(px1), int'(e_px[1]));
      chk("busy0", int'(busy0), int'(e_busy));
      chk("busy1", int'(busy1), int'(e_busy));
      chk("shown0", int'(shown0), int'(e_shown));
      chk("shown1", int'(shown1), int'(e_shown));
    end
  end

  task automatic req(input logic [7:0] xy, input logic [3:0] ln);
    char_xy = xy; char_line = ln;
    repeat (2) @(negedge clk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (busy0) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_pass(input bit want_shown);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (busy0) seen = 1'b1;
      else if (seen) break;
    end
    chk("pass_end", (seen && !busy0) ? 1 : 0, 1);
    chk("pass_shown", int'(shown0), int'(want_shown));
  endtask

  initial begin
    int n, lat, nz;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_px", int'(px0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_shown", int'(shown0), 0);

    rst_n = 1'b1;
    busy_len(n);
    chk("busy_len_after_reset", n, 256);
    req(8'h35, 4'd4);
    chk("idle_space_3_5", int'(px0), 8'h00);

    endgame = 1'b1;
    @(negedge clk);
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      if (j == 257) begin char_xy = 8'h27; char_line = 4'd4; end
      @(negedge clk);
      if (j == 258) chk("same_cycle_old", int'(px0), 8'h00);
      if (j == 259) chk("same_cycle_new", int'(px0), 8'h7C);
      if (shown0 && lat < 0) lat = j;
    end
    chk("shown_latency", lat, 270);
    req(8'h27, 4'd6);
    chk("p1_P_line6", int'(px0), 8'h66);
    req(8'hE7, 4'd8);
    chk("p1_S_line8", int'(px0), 8'h06);
    req(8'hA7, 4'd4);
    chk("wrap_P_col10", int'(px1), 8'h7C);
    req(8'h67, 4'd4);
    chk("wrap_S_col6", int'(px1), 8'h3C);

    endgame2 = 1'b1;
    wait_pass(1'b1);
    req(8'h27, 4'd4);
    chk("draw_D", int'(px0), 8'h78);
    req(8'h57, 4'd4);
    chk("draw_W", int'(px0), 8'h63);
    req(8'h67, 4'd4);
    chk("draw_col6_space", int'(px0), 8'h00);

    endgame = 1'b0; endgame2 = 1'b0;
    wait_pass(1'b0);
    nz = 0;
    char_line = 4'd5;
    for (int a = 0; a < 258; a++) begin
      char_xy = 8'(a);
      @(negedge clk);
      if (px0 != 8'h00) nz++;
    end
    chk("scan_all_space", nz, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (j == 100) endgame = 1'b1;
      if (shown0 && lat < 0) lat = j;
    end
    chk("late_sel_latency", lat, 270);

    endgame = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midpass_rst_busy", int'(busy0), 0);
    rst_n = 1'b1;
    busy_len(n);
    chk("busy_len_after_midpass_rst", n, 256);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
